syscall_console: RTL and testbench
==================================

// Module: syscall_console
// PURPOSE
//  Operator-side partner of the CPU's SYSCALL halt/display interface: consumes the 32-bit display word and halt
//  flag, shows the word on an 8-digit multiplexed 7-segment display, and turns the raw GO push-button into a
//  clean one-cycle GO pulse back to the pipeline. Sits at board top level beside the CPU core.
// PARAMETERS
//  SCAN_DIV      16'd50000  clk cycles each digit stays lit (>=1)
//  DEBOUNCE_CNT  20'd1000000  consecutive stable synced samples required to accept a button level change (>=1)
// PORTS
//  clk      in   1   system clock, all state on rising edge
//  CLR      in   1   reset; asynchronous, active-high
//  display  in   32  word from SYSCALL control, 8 hex nibbles
//  halt     in   1   CPU halted, waiting for GO
//  btn_go   in   1   raw async push-button, 1 = pressed
//  GO       out  1   registered one-cycle resume pulse to CPU
//  an       out  8   digit enables, active-low, an[0] = rightmost digit
//  seg      out  7   segments {g,f,e,d,c,b,a}, active-low
//  dp       out  1   decimal point, active-low
//  shown    out  32  frame-coherent snapshot currently displayed
// BEHAVIOUR
//  Reset (CLR=1, async): an=8'hFF, seg=7'h7F, dp=1, GO=0, shown=0, div=0, idx=0, debounce FSM=REL_WAIT, count=0.
//  Sync: btn_go through 2-flop synchroniser -> btn_s (2-cycle latency); FSM sees only btn_s.
//  Scan: div counts 0..SCAN_DIV-1; at div==SCAN_DIV-1 ("tick") div<=0, idx<=idx+1 mod 8 (7->0 wraps).
//  Snapshot: on the tick where idx wraps 7->0, shown<=display; no other update, so no torn frames.
//   Display change visible within 8*SCAN_DIV+1 cycles; changes held < one frame may be missed (intended).
//  Drive (registered, 1 cycle after idx): an=~(8'b1<<idx); seg=hex7seg(shown[4*idx+:4]), 0-F incl. A,b,C,d,E,F;
//   dp=0 only when idx==0 && halt==1, else 1.
//  Debounce FSM, count resets to 0 on every state change:
//   REL_WAIT: btn_s==0 -> count++; btn_s==1 -> count<=0; count reaches DEBOUNCE_CNT-1 with btn_s==0 -> RELEASED.
//   RELEASED: btn_s==1 -> PRESS_WAIT.
//   PRESS_WAIT: btn_s==1 -> count++; btn_s==0 -> RELEASED (bounce rejected); count reaches DEBOUNCE_CNT-1 -> HELD.
//   HELD: GO=1 for the single cycle of entry iff halt==1 that cycle, else press consumed silently; btn_s==0 -> REL_WAIT.
//  Held button gives exactly one GO; next GO needs a debounced release first.
//  Reset into REL_WAIT: button held across reset never produces a GO until released and re-pressed.
//  SCAN_DIV==1: idx advances every cycle. Reset mid-frame/mid-press: everything returns to reset values, no GO.
//  Counters are sized to hold their parameter value; no wrap beyond terminal values.
// CONFIGURATION
//  BLANK_LEADING_ZERO_EN defined: digit k (k>=1) is blanked (an bit held 1) when shown[31:4k]==0; digit 0 is
//   always lit, so shown==0 lights one '0'. Scan timing unchanged (blanked slots stay dark for SCAN_DIV).
//  Not defined: all 8 digits always lit, leading zeros shown.
// TESTING (SCAN_DIV=4, DEBOUNCE_CNT=8)
//  Reset: CLR pulse mid-scan -> an=FF, seg=7F, dp=1, GO=0, shown=0 same cycle, asynchronously.
//  Scan: display=32'h1234ABCD held -> after first wrap shown=1234ABCD; an steps FE,FD,..,7F every 4 cycles;
//   digit0 seg=7'h21 ('d'), digit7 seg=7'h79 ('1').
//  Snapshot: display changes 12345678->0000000F mid-frame -> shown keeps 12345678 until next 7->0 wrap.
//  Debounce: halt=1, btn_go toggles every 3 cycles for 30, then held 1 -> exactly one GO pulse,
//   ~8+2 cycles after the stable hold starts; none during bouncing.
//  Gating/hold: halt=0 clean press -> no GO; halt=1, button held 200 cycles -> one GO;
//   button held through CLR release -> no GO until released >=8 cycles and pressed >=8 cycles.
//  Macro: BLANK_LEADING_ZERO_EN, shown=32'h000000A5 -> only an[1:0] ever low; shown=0 -> only an[0] low, seg=7'h40.

Source files
------------

// File: rtl/syscall_console_if.sv
// Signal bundle between the CPU/board side and the SYSCALL operator console.
// master = CPU/board side, slave = console.
interface syscall_console_if;
    logic [31:0] display;
    logic        halt;
    logic        btn_go;
    logic        GO;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [31:0] shown;
    logic [1:0]  dbg_state;

    // GO is a registered single-cycle pulse with no ready: the CPU must sample it on the cycle it is high.
    modport master (
        output display, halt, btn_go,
        input  GO, an, seg, dp, shown, dbg_state
    );
    modport slave (
        input  display, halt, btn_go,
        output GO, an, seg, dp, shown, dbg_state
    );
endinterface

// File: rtl/syscall_console.sv
// SYSCALL operator console: 8-digit multiplexed hex display of the halt word plus a debounced GO button.
// Optional macro BLANK_LEADING_ZERO_EN darkens leading zero digits (digit 0 always lit).
module syscall_console #(
    parameter logic [15:0] SCAN_DIV     = 16'd50000,
    parameter logic [19:0] DEBOUNCE_CNT = 20'd1000000
) (
    input logic          clk,
    input logic          CLR,
    syscall_console_if.slave bus
);

    typedef enum logic [1:0] {
        REL_WAIT   = 2'd0,
        RELEASED   = 2'd1,
        PRESS_WAIT = 2'd2,
        HELD       = 2'd3
    } deb_state_t;

    logic        btn_m, btn_s;
    logic [15:0] div;
    logic [2:0]  idx;
    logic [31:0] shown;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        go;
    logic        tick;
    logic        blank;
    logic [7:0]  an_next;

    deb_state_t  state, state_next;
    logic [19:0] count, count_next;
    logic        go_next;

    function automatic logic [6:0] hex7seg(input logic [3:0] v);
        case (v)
            4'h0: hex7seg = 7'h40;
            4'h1: hex7seg = 7'h79;
            4'h2: hex7seg = 7'h24;
            4'h3: hex7seg = 7'h30;
            4'h4: hex7seg = 7'h19;
            4'h5: hex7seg = 7'h12;
            4'h6: hex7seg = 7'h02;
            4'h7: hex7seg = 7'h78;
            4'h8: hex7seg = 7'h00;
            4'h9: hex7seg = 7'h10;
            4'hA: hex7seg = 7'h08;
            4'hB: hex7seg = 7'h03;
            4'hC: hex7seg = 7'h46;
            4'hD: hex7seg = 7'h21;
            4'hE: hex7seg = 7'h06;
            default: hex7seg = 7'h0E;
        endcase
    endfunction

    assign tick = (div == SCAN_DIV - 16'd1);

`ifdef BLANK_LEADING_ZERO_EN
    assign blank = (idx != 3'd0) && ((shown >> {idx, 2'b00}) == 32'd0);
`else
    assign blank = 1'b0;
`endif

    assign an_next = ~(8'b1 << idx) | {8{blank}};

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            btn_m <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            btn_m <= bus.btn_go;
            btn_s <= btn_m;
        end
    end

    // shown only reloads when the scan wraps, so a frame never mixes two display words
    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            div   <= 16'd0;
            idx   <= 3'd0;
            shown <= 32'd0;
            an    <= 8'hFF;
            seg   <= 7'h7F;
            dp    <= 1'b1;
        end else begin
            if (tick) begin
                div <= 16'd0;
                idx <= idx + 3'd1;
                if (idx == 3'd7) shown <= bus.display;
            end else begin
                div <= div + 16'd1;
            end
            an  <= an_next;
            seg <= hex7seg(shown[{idx, 2'b00} +: 4]);
            dp  <= ~((idx == 3'd0) && bus.halt);
        end
    end

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            state <= REL_WAIT;
            count <= 20'd0;
            go    <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            go    <= go_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        go_next    = 1'b0;
        case (state)
            REL_WAIT: begin
                if (btn_s) begin
                    count_next = 20'd0;
                end else if (count == DEBOUNCE_CNT - 20'd1) begin
                    state_next = RELEASED;
                    count_next = 20'd0;
                end else begin
                    count_next = count + 20'd1;
                end
            end
            RELEASED: begin
                if (btn_s) begin
                    state_next = PRESS_WAIT;
                    count_next = 20'd0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_next = RELEASED;
                    count_next = 20'd0;
                end else if (count == DEBOUNCE_CNT - 20'd1) begin
                    // a press accepted while the CPU is running is consumed without a pulse
                    state_next = HELD;
                    count_next = 20'd0;
                    go_next    = bus.halt;
                end else begin
                    count_next = count + 20'd1;
                end
            end
            default: begin
                if (!btn_s) begin
                    state_next = REL_WAIT;
                    count_next = 20'd0;
                end
            end
        endcase
    end

    assign bus.GO        = go;
    assign bus.an        = an;
    assign bus.seg       = seg;
    assign bus.dp        = dp;
    assign bus.shown     = shown;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_syscall_console.sv
// Directed self-checking bench for syscall_console with SCAN_DIV=4, DEBOUNCE_CNT=8.
module tb_syscall_console;

    logic clk;
    logic CLR;
    int   n_checks;
    int   n_errors;

    syscall_console_if bus ();

    syscall_console #(
        .SCAN_DIV(16'd4),
        .DEBOUNCE_CNT(20'd8)
    ) dut (
        .clk(clk),
        .CLR(CLR),
        .bus(bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // active-low {g,f,e,d,c,b,a} patterns for 0..F
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic wait_shown(input string tag, input logic [31:0] exp);
        int k;
        k = 0;
        while (bus.shown !== exp && k < 40) begin
            step(1);
            k++;
        end
        check(tag, bus.shown, exp);
    endtask

    task automatic run_count(input int n, output int pulses, output int first);
        pulses = 0;
        first  = -1;
        for (int i = 1; i <= n; i++) begin
            step(1);
            if (bus.GO === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
    endtask

    task automatic frame_lit(output logic [7:0] lit, output logic [6:0] seg0);
        lit  = 8'h00;
        seg0 = 7'h7F;
        for (int i = 0; i < 40; i++) begin
            step(1);
            lit = lit | ~bus.an;
            if (bus.an == 8'hFE) seg0 = bus.seg;
        end
    endtask

    initial begin
        int p, f, total;
        logic [31:0] word;
        logic [7:0]  lit;
        logic [6:0]  s0;
        n_checks = 0;
        n_errors = 0;
        CLR = 1'b1;
        bus.display = 32'h1234ABCD;
        bus.halt    = 1'b0;
        bus.btn_go  = 1'b0;

        #13;
        check("rst_an", {24'd0, bus.an}, 32'hFF);
        check("rst_seg", {25'd0, bus.seg}, 32'h7F);
        check("rst_dp", {31'd0, bus.dp}, 32'd1);
        check("rst_go", {31'd0, bus.GO}, 32'd0);
        check("rst_shown", bus.shown, 32'd0);
        @(negedge clk);
        CLR = 1'b0;

        // scan: digit k visible from edge 1+4k after the snapshot lands
        wait_shown("scan_shown", 32'h1234ABCD);
        bus.halt = 1'b1;
        word = 32'h1234ABCD;
        step(1);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("scan_an%0d", k), {24'd0, bus.an}, {24'd0, ~(8'b1 << k)});
            check($sformatf("scan_seg%0d", k), {25'd0, bus.seg}, {25'd0, seg_tab[word[4*k +: 4]]});
            check($sformatf("scan_dp%0d", k), {31'd0, bus.dp}, (k == 0) ? 32'd0 : 32'd1);
            step(4);
        end
        bus.halt = 1'b0;

        // snapshot coherence
        bus.display = 32'h12345678;
        wait_shown("snap_first", 32'h12345678);
        step(5);
        bus.display = 32'h0000000F;
        step(5);
        check("snap_hold", bus.shown, 32'h12345678);
        wait_shown("snap_next", 32'h0000000F);

        // leading-zero behaviour
        bus.display = 32'h000000A5;
        wait_shown("lz_a5_shown", 32'h000000A5);
        frame_lit(lit, s0);
`ifdef BLANK_LEADING_ZERO_EN
        check("lz_a5_lit", {24'd0, lit}, 32'h03);
`else
        check("lz_a5_lit", {24'd0, lit}, 32'hFF);
`endif
        bus.display = 32'h00000000;
        wait_shown("lz_zero_shown", 32'h0);
        frame_lit(lit, s0);
`ifdef BLANK_LEADING_ZERO_EN
        check("lz_zero_lit", {24'd0, lit}, 32'h01);
`else
        check("lz_zero_lit", {24'd0, lit}, 32'hFF);
`endif
        check("lz_zero_seg", {25'd0, s0}, 32'h40);

        // debounce with bouncing input
        bus.halt = 1'b1;
        step(12);
        total = 0;
        for (int t = 0; t < 10; t++) begin
            bus.btn_go = ~t[0];
            run_count(3, p, f);
            total += p;
        end
        check("bounce_no_go", total, 0);
        bus.btn_go = 1'b1;
        run_count(40, p, f);
        check("bounce_one_go", p, 1);
        check("bounce_latency_ok", (f >= 8 && f <= 14) ? 32'd1 : 32'd0, 32'd1);
        bus.btn_go = 1'b0;
        step(20);

        // halt low: press consumed silently
        bus.halt = 1'b0;
        bus.btn_go = 1'b1;
        run_count(20, p, f);
        check("gate_no_go", p, 0);
        bus.btn_go = 1'b0;
        step(20);

        // long hold: exactly one pulse
        bus.halt = 1'b1;
        bus.btn_go = 1'b1;
        run_count(200, p, f);
        check("hold_one_go", p, 1);
        bus.btn_go = 1'b0;
        step(20);

        // mid-press async reset with button held across it
        bus.btn_go = 1'b1;
        step(6);
        #3;
        CLR = 1'b1;
        #1;
        check("midrst_an", {24'd0, bus.an}, 32'hFF);
        check("midrst_seg", {25'd0, bus.seg}, 32'h7F);
        check("midrst_dp", {31'd0, bus.dp}, 32'd1);
        check("midrst_go", {31'd0, bus.GO}, 32'd0);
        check("midrst_shown", bus.shown, 32'd0);
        step(3);
        CLR = 1'b0;
        run_count(50, p, f);
        check("held_rst_no_go", p, 0);
        bus.btn_go = 1'b0;
        run_count(15, p, f);
        check("held_rst_release_no_go", p, 0);
        bus.btn_go = 1'b1;
        run_count(20, p, f);
        check("held_rst_repress_go", p, 1);
        bus.btn_go = 1'b0;
        step(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
